tlul_copy_engine: RTL and testbench
===================================

// Module: tlul_copy_engine
// PURPOSE
//  TL-UL host (initiator) that copies a block of 32-bit words from a source to a destination address.
//  It is the requesting end of the same bus that sram-class devices answer.
//  It reads a chunk of up to BufDepth words into a local buffer, then writes that chunk out, and repeats.
//  It carries each word's capability tag, so copies between tagged memories keep the tag.
//  It sits on a crossbar host port, driven by a control block (or a CPU register shim).
// PARAMETERS
//  BufDepth   4   words buffered per chunk; power of two, 2..16
//  LenWidth   16  width of the word-count input
// PORTS
//  clk_i        in   1         clock
//  rst_i        in   1         synchronous, active-high reset
//  start_i      in   1         start copy; sampled only in IDLE
//  src_addr_i   in   32        source byte address; must be word aligned
//  dst_addr_i   in   32        destination byte address; must be word aligned
//  len_i        in   LenWidth  number of words to copy
//  busy_o       out  1         high from the cycle after an accepted start until DONE
//  done_o       out  1         one-cycle pulse at completion (also on error)
//  err_o        out  1         sticky error flag; cleared by the next accepted start
//  tl_o         out  tl_h2d_t  TL-UL A channel and d_ready
//  tl_i         in   tl_d2h_t  TL-UL D channel and a_ready
// BEHAVIOUR
//  Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
//  Reset values: busy_o=0, done_o=0, err_o=0, a_valid=0, d_ready=1, FSM=IDLE, counters=0.
//  FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
//   IDLE: on start_i, latch src, dst and len; clear err_o.
//    - If src[1:0] or dst[1:0] is nonzero: go to FIN with err_o=1.
//    - Else if len==0: go to FIN.
//    - Else: go to RD_REQ; set chunk = min(BufDepth, remaining).
//   RD_REQ: a_valid=1, a_opcode=Get, a_address=src.
//    - On a_ready: go to RD_WAIT.
//   RD_WAIT: on d_valid, store d_data and d_user.capability in buf[idx].
//    - Then src+=4 and idx++.
//    - If idx==chunk: idx=0 and go to WR_REQ. Else go to RD_REQ.
//   WR_REQ: a_valid=1, a_opcode=PutFullData, a_address=dst, a_data=buf[idx].
//    - a_user.capability = tag[idx].
//    - On a_ready: go to WR_WAIT.
//   WR_WAIT: on d_valid (AccessAck): dst+=4, idx++, remaining--.
//    - If remaining==0: go to FIN.
//    - Else if idx==chunk: start a new chunk in RD_REQ.
//    - Else: go to WR_REQ.
//   FIN: done_o=1 for exactly one cycle, busy_o=0, then return to IDLE.
//  A-channel fields: a_size=2, a_mask=4'hF, a_source=0, a_param=0.
//   Integrity fields come from tlul_cmd_intg_gen and tlul_data_intg_gen.
//  Handshakes:
//   - At most one transaction is outstanding.
//   - A-channel fields stay stable while a_valid=1 && !a_ready.
//   - d_ready is always 1; a D beat accepted in the same cycle as a_valid is legal.
//  Error: d_error=1 in RD_WAIT or WR_WAIT ends the copy.
//   - Go to FIN with err_o=1; no further requests are issued.
//   - A partial destination write is acceptable.
//  Address arithmetic: 32-bit wrap-around at 2^32 is silent and not an error.
//  Simultaneous events: start_i while busy is ignored. An unexpected d_valid in IDLE is dropped.
//  Reset mid-operation: FSM returns to IDLE and a_valid drops in the next cycle.
//   A D response still in flight arrives in IDLE and is dropped.
//  Latency: 2 cycles per word per direction at zero wait states.
//   Total = 4*len + 2 cycles from start to done (IDLE exit through FIN).
// STRUCTURE
//  Shared package tlul_copy_pkg: copy_state_e FSM enum; localparam WordBytes=4.
//  Data buffer: a flop array of BufDepth x 33 bits (32 data + 1 tag); no RAM macro.
//  Sub-module: none beyond the existing tlul_cmd_intg_gen and tlul_data_intg_gen.
// TESTING
//  1. src=0x100 holds 0..9, dst=0x200, len=10, BufDepth=4, zero-wait device.
//     -> dst holds 0..9; done_o after 42 cycles; err_o=0; reads and writes in chunks 4/4/2.
//  2. len=0 -> done_o pulses 2 cycles after start; no A-channel valid ever seen.
//  3. src=0x102 -> no bus traffic; done_o pulses; err_o=1.
//     A following valid start clears err_o.
//  4. Device holds a_ready low for 5 cycles on the 3rd write -> A fields stable throughout; data intact.
//  5. d_error on the 2nd read of len=6 -> no writes issued; done_o; err_o=1.
//  6. Tagged source word (cap=1) at 0x300, len=1 -> write carries a_user.capability=1.
//     Assert rst_i during WR_WAIT -> IDLE, busy_o=0, stray D beat ignored.

Source files
------------

// File: rtl/tlul_copy_engine_pkg.sv
// Shared types for the TL-UL copy engine: FSM states, TL-UL channel structs and integrity folding.
// The A/D structs carry a one-bit capability tag in the user field alongside command and data integrity.
package tlul_copy_pkg;

   localparam int WordBytes = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      FIN
   } copy_state_e;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic       capability;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic       capability;
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   // XOR-folds a 64-bit payload into 7 check bits.
   function automatic logic [6:0] intg_fold(input logic [63:0] v);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r = r ^ 7'(v >> (7 * i));
      end
      return r;
   endfunction

endpackage

// File: rtl/tlul_copy_engine_if.sv
// TL-UL host/device channel pair; master drives the A channel and d_ready, slave answers on D and a_ready.
interface tlul_copy_engine_if;
   import tlul_copy_pkg::*;

   tl_h2d_t h2d;
   tl_d2h_t d2h;

   modport master (output h2d, input d2h);
   modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_copy_engine_intg.sv
// Command and data integrity for one A-channel beat; combinational, no state.
module tlul_copy_engine_intg
   import tlul_copy_pkg::*;
(
   input  tl_a_op_e    opcode,
   input  logic [31:0] address,
   input  logic [3:0]  mask,
   input  logic [31:0] data,
   output logic [6:0]  cmd_intg,
   output logic [6:0]  data_intg
);
   assign cmd_intg  = intg_fold({25'd0, opcode, mask, address});
   assign data_intg = intg_fold({32'd0, data});
endmodule

// File: rtl/tlul_copy_engine.sv
// TL-UL host copying len tagged words src->dst in chunks of BufDepth; 4*len+2 cycles start-to-done at zero wait.
// One request outstanding; A fields held while a_ready is low; d_ready is tied high.
module tlul_copy_engine
   import tlul_copy_pkg::*;
#(
   parameter int BufDepth = 4,
   parameter int LenWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [31:0]         src_addr_i,
   input  logic [31:0]         dst_addr_i,
   input  logic [LenWidth-1:0] len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   tlul_copy_engine_if.master  tl
);
   localparam int PtrW = $clog2(BufDepth);
   localparam int IdxW = PtrW + 1;

   copy_state_e         state_q, state_d;
   logic [31:0]         src_q, dst_q;
   logic [LenWidth-1:0] remaining_q;
   logic [IdxW-1:0]     chunk_q, idx_q, idx_inc;
   logic                busy_q, done_q, err_q;
   logic [31:0]         buf_dat [BufDepth];
   logic                buf_tag [BufDepth];
   logic                misaligned, chunk_end, d_ok, d_bad;
   logic                a_valid, a_cap;
   tl_a_op_e            a_opcode;
   logic [31:0]         a_address, a_data;
   logic [6:0]          cmd_intg, data_intg;
   logic                unused_d2h;

   function automatic logic [IdxW-1:0] chunk_of(input logic [LenWidth-1:0] n);
      if (n >= LenWidth'(BufDepth)) return IdxW'(BufDepth);
      return n[IdxW-1:0];
   endfunction

   assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
   assign idx_inc    = idx_q + IdxW'(1);
   assign chunk_end  = (idx_inc == chunk_q);
   assign d_ok       = tl.d2h.d_valid && !tl.d2h.d_error;
   assign d_bad      = tl.d2h.d_valid && tl.d2h.d_error;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      a_valid   = 1'b0;
      a_opcode  = Get;
      a_address = src_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = (misaligned || len_i == '0) ? FIN : RD_REQ;
         end
         RD_REQ: begin
            a_valid = 1'b1;
            if (tl.d2h.a_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (d_bad)     state_d = FIN;
            else if (d_ok) state_d = chunk_end ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            a_valid   = 1'b1;
            a_opcode  = PutFullData;
            a_address = dst_q;
            if (tl.d2h.a_ready) state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (d_bad) state_d = FIN;
            else if (d_ok) begin
               if (remaining_q == LenWidth'(1)) state_d = FIN;
               else if (chunk_end)              state_d = RD_REQ;
               else                             state_d = WR_REQ;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         chunk_q     <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= (state_q == FIN);
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q       <= src_addr_i;
                  dst_q       <= dst_addr_i;
                  remaining_q <= len_i;
                  chunk_q     <= chunk_of(len_i);
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  err_q       <= misaligned;
               end
            end
            RD_WAIT: begin
               if (d_bad) err_q <= 1'b1;
               else if (d_ok) begin
                  src_q <= src_q + 32'(WordBytes);
                  idx_q <= chunk_end ? '0 : idx_inc;
               end
            end
            WR_WAIT: begin
               if (d_bad) err_q <= 1'b1;
               else if (d_ok) begin
                  dst_q       <= dst_q + 32'(WordBytes);
                  remaining_q <= remaining_q - LenWidth'(1);
                  if (chunk_end) begin
                     idx_q   <= '0;
                     chunk_q <= chunk_of(remaining_q - LenWidth'(1));
                  end else begin
                     idx_q <= idx_inc;
                  end
               end
            end
            FIN:     busy_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // Buffer holds data only; validity is tracked by idx/chunk, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (state_q == RD_WAIT && d_ok) begin
         buf_dat[idx_q[PtrW-1:0]] <= tl.d2h.d_data;
         buf_tag[idx_q[PtrW-1:0]] <= tl.d2h.d_user.capability;
      end
   end

   assign a_data = (state_q == WR_REQ) ? buf_dat[idx_q[PtrW-1:0]] : '0;
   assign a_cap  = (state_q == WR_REQ) ? buf_tag[idx_q[PtrW-1:0]] : 1'b0;

   tlul_copy_engine_intg u_intg (
      .opcode    (a_opcode),
      .address   (a_address),
      .mask      (4'hF),
      .data      (a_data),
      .cmd_intg  (cmd_intg),
      .data_intg (data_intg)
   );

   always_comb begin
      tl.h2d                     = '0;
      tl.h2d.a_valid             = a_valid;
      tl.h2d.a_opcode            = a_opcode;
      tl.h2d.a_param             = 3'd0;
      tl.h2d.a_size              = 2'd2;
      tl.h2d.a_source            = 8'd0;
      tl.h2d.a_address           = a_address;
      tl.h2d.a_mask              = 4'hF;
      tl.h2d.a_data              = a_data;
      tl.h2d.a_user.capability   = a_cap;
      tl.h2d.a_user.cmd_intg     = cmd_intg;
      tl.h2d.a_user.data_intg    = data_intg;
      tl.h2d.d_ready             = 1'b1;
   end

   assign unused_d2h = ^{tl.d2h.d_opcode, tl.d2h.d_param, tl.d2h.d_size, tl.d2h.d_source,
                         tl.d2h.d_sink, tl.d2h.d_user.rsp_intg, tl.d2h.d_user.data_intg};

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;
endmodule

// File: tb/tb_tlul_copy_engine.sv
// Scoreboarded bench: stimulus queues expected A beats and done events, a device/monitor process checks them.
module tb_tlul_copy_engine;
   import tlul_copy_pkg::*;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] dat;
      logic        cap;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len;
   logic        busy, done, err;

   tlul_copy_engine_if tl_if ();

   tlul_copy_engine #(.BufDepth(4), .LenWidth(16)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .src_addr_i (src_addr),
      .dst_addr_i (dst_addr),
      .len_i      (len),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .tl         (tl_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   logic [32:0] mem [logic [31:0]];
   exp_t exp_a [$];
   int   exp_done_cyc [$];
   bit   exp_done_err [$];

   // device configuration written by stimulus, read by the device
   int   d_delay = 0;
   int   err_rd_idx = -1;
   int   stall_wr_idx = -1;
   int   stall_cycles = 0;
   // device bookkeeping
   int   rd_count = 0;
   int   wr_count = 0;
   int   stall_cnt = 0;
   bit   pend_vld = 0;
   int   pend_cnt = 0;
   tl_d_op_e pend_op;
   logic [32:0] pend_dat;
   bit   pend_err;
   bit   have_snap = 0;
   tl_h2d_t snap;
   bit   prev_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   // Device model and monitor: responds one cycle after acceptance (plus d_delay), checks every A beat.
   always @(negedge clk) begin
      tl_d2h_t d;
      tl_h2d_t h;
      exp_t    e, act;
      h = tl_if.h2d;
      d = '0;
      d.a_ready = 1'b1;
      if (pend_vld) begin
         if (pend_cnt == 0) begin
            d.d_valid           = 1'b1;
            d.d_opcode          = pend_op;
            d.d_data            = pend_dat[31:0];
            d.d_user.capability = pend_dat[32];
            d.d_error           = pend_err;
            pend_vld            = 0;
         end else begin
            pend_cnt--;
         end
      end
      if (h.a_valid === 1'b1 && h.a_opcode == PutFullData && wr_count == stall_wr_idx
          && stall_cnt < stall_cycles) begin
         d.a_ready = 1'b0;
         stall_cnt++;
      end
      tl_if.d2h = d;

      if (h.a_valid === 1'b1 && !d.a_ready) begin
         if (have_snap) check("a_stable", h, snap);
         else begin
            snap      = h;
            have_snap = 1;
         end
      end
      if (h.a_valid === 1'b1 && d.a_ready) begin
         if (have_snap) check("a_stable_accept", h, snap);
         have_snap = 0;
         act.op   = h.a_opcode;
         act.addr = h.a_address;
         act.dat  = (h.a_opcode == PutFullData) ? h.a_data : 32'd0;
         act.cap  = (h.a_opcode == PutFullData) ? h.a_user.capability : 1'b0;
         check("a_expected", exp_a.size() != 0, 1);
         if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            check("a_txn", act, e);
         end
         check("a_fixed", {h.a_size, h.a_mask, h.a_source, h.a_param, h.d_ready},
               {2'd2, 4'hF, 8'd0, 3'd0, 1'b1});
         pend_vld = 1;
         pend_cnt = d_delay;
         if (h.a_opcode == Get) begin
            pend_op  = AccessAckData;
            pend_dat = mem.exists(h.a_address) ? mem[h.a_address] : 33'd0;
            pend_err = (rd_count == err_rd_idx);
            rd_count++;
         end else begin
            mem[h.a_address] = {h.a_user.capability, h.a_data};
            pend_op  = AccessAck;
            pend_dat = '0;
            pend_err = 0;
            wr_count++;
         end
      end

      if (prev_done) check("done_one_cycle", done, 1'b0);
      if (done === 1'b1 && !prev_done) begin
         check("done_expected", exp_done_cyc.size() != 0, 1);
         if (exp_done_cyc.size() != 0) begin
            check("done_cycle", cyc, exp_done_cyc.pop_front());
            check("done_err", err, exp_done_err.pop_front());
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic push_txn(input tl_a_op_e op, input logic [31:0] a, input logic [31:0] dv, input logic c);
      exp_t e;
      e.op   = op;
      e.addr = a;
      e.dat  = dv;
      e.cap  = c;
      exp_a.push_back(e);
   endtask

   // Expected A sequence for an error-free copy of n words whose values are dbase+i, in chunks of 4.
   task automatic push_copy(input logic [31:0] s, input logic [31:0] dd, input int n, input logic [31:0] dbase);
      for (int b = 0; b < n; b += 4) begin
         int c;
         c = (n - b < 4) ? n - b : 4;
         for (int j = 0; j < c; j++) push_txn(Get, s + 32'(4 * (b + j)), 32'd0, 1'b0);
         for (int j = 0; j < c; j++) push_txn(PutFullData, dd + 32'(4 * (b + j)), dbase + 32'(b + j), 1'b0);
      end
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] dd, input logic [15:0] n,
                           input bit expect_done, input bit err_final, input int lat);
      @(negedge clk);
      src_addr = s;
      dst_addr = dd;
      len      = n;
      start    = 1'b1;
      if (expect_done) begin
         exp_done_cyc.push_back(cyc + lat);
         exp_done_err.push_back(err_final);
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("err_after_start", err, (s[1:0] != 2'b00) || (dd[1:0] != 2'b00));
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 300 && exp_done_cyc.size() != 0; i++) @(negedge clk);
      check(name, exp_done_cyc.size(), 0);
      check({name, "_a_drained"}, exp_a.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      for (int i = 0; i < 10; i++) mem[32'h100 + 32'(4 * i)] = 33'(i);
      for (int i = 0; i < 4; i++)  mem[32'h700 + 32'(4 * i)] = {1'b0, 32'hA5A50000 + 32'(i)};
      mem[32'h300] = {1'b1, 32'hCAFEF00D};

      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, err, tl_if.h2d.a_valid, tl_if.h2d.d_ready}, 5'b00001);
      rst = 1'b0;

      // 1: ten words in chunks 4/4/2
      push_copy(32'h100, 32'h200, 10, 32'd0);
      do_start(32'h100, 32'h200, 16'd10, 1, 0, 42);
      wait_done("t1_done");
      for (int i = 0; i < 10; i++) check("t1_dst_word", mem[32'h200 + 32'(4 * i)], 33'(i));

      // 2: zero length
      do_start(32'h100, 32'h200, 16'd0, 1, 0, 2);
      wait_done("t2_done");

      // 3: misaligned source, then a clean start clears the error
      do_start(32'h102, 32'h200, 16'd3, 1, 1, 2);
      wait_done("t3_done");
      check("t3_err_sticky", err, 1'b1);
      push_copy(32'h100, 32'h500, 1, 32'd0);
      do_start(32'h100, 32'h500, 16'd1, 1, 0, 6);
      wait_done("t3b_done");
      check("t3b_err_clear", err, 1'b0);

      // 4: third write stalled for 5 cycles; a start pulse while busy is ignored
      stall_wr_idx = wr_count + 2;
      stall_cycles = 5;
      push_copy(32'h700, 32'h800, 4, 32'hA5A50000);
      do_start(32'h700, 32'h800, 16'd4, 1, 0, 23);
      @(negedge clk);
      src_addr = 32'h900;
      dst_addr = 32'hA00;
      len      = 16'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t4_done");
      for (int i = 0; i < 4; i++)
         check("t4_dst_word", mem[32'h800 + 32'(4 * i)], {1'b0, 32'hA5A50000 + 32'(i)});

      // 5: error on the second read stops the copy before any write
      err_rd_idx = rd_count + 1;
      push_txn(Get, 32'h100, 32'd0, 1'b0);
      push_txn(Get, 32'h104, 32'd0, 1'b0);
      do_start(32'h100, 32'h600, 16'd6, 1, 1, 6);
      wait_done("t5_done");
      check("t5_no_write", mem.exists(32'h600), 0);

      // 6: tagged word keeps its tag; reset lands during WR_WAIT with the ack still in flight
      d_delay = 2;
      push_txn(Get, 32'h300, 32'd0, 1'b0);
      push_txn(PutFullData, 32'h400, 32'hCAFEF00D, 1'b1);
      begin
         int target;
         bit seen;
         target = wr_count + 1;
         seen   = 0;
         do_start(32'h300, 32'h400, 16'd1, 0, 0, 0);
         for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (wr_count == target) seen = 1;
         end
         check("t6_write_seen", seen, 1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_reset_idle", {busy, tl_if.h2d.a_valid}, 2'b00);
      repeat (6) @(negedge clk);
      check("t6_after_stray_d", {busy, done, err, tl_if.h2d.a_valid}, 4'b0000);
      check("t6_a_drained", exp_a.size(), 0);
      check("t6_no_done", exp_done_cyc.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end
endmodule
